// File: rtl/arb_pkg.sv
// Shared types and constants for the 2:1 round-robin bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic arb_state_t grant_of(input logic s);
        return (s == SEL_B) ? ST_GNT_B : ST_GNT_A;
    endfunction

endpackage

// File: rtl/MUX_32Bits.sv
// Team 2:1 data mux; select 0 passes d0, select 1 passes d1.
module MUX_32Bits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             select,
    output logic [WIDTH-1:0] y
);

    assign y = select ? d1 : d0;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Per-beat round-robin arbiter sharing one datapath between requesters A and B,
// with a one-entry output register. Define ARB_LOCK_EN to add a_lock/b_lock bus retention.
//
// state    | meaning
// ST_IDLE  | no grant; sel holds its last value
// ST_GNT_A | A owns the mux (sel=0), a_ready when output stage is free
// ST_GNT_B | B owns the mux (sel=1), b_ready when output stage is free
module bus_arbiter_2to1
    import arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef ARB_LOCK_EN
    ,
    input  logic             a_lock,
    input  logic             b_lock
`endif
);

    if (LOCK_MAX < 2) begin : g_bad_lock_max
        $error("LOCK_MAX must be at least 2");
    end

    arb_state_t       state, state_nxt;
    logic             sel_nxt;
    logic             last, last_nxt;
    logic             free, xfer_a, xfer_b, own_xfer;
    logic             own_valid, other_valid, hold_lock;
    logic [WIDTH-1:0] mux_data;

`ifdef ARB_LOCK_EN
    localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
    logic           own_lock, lock_at_max;

    assign own_lock    = (sel == SEL_B) ? b_lock : a_lock;
    assign lock_at_max = (lock_cnt == LCW'(LOCK_MAX - 1));
    assign hold_lock   = own_lock && !(lock_at_max && other_valid);
`else
    assign hold_lock   = 1'b0;
`endif

    assign free        = !out_valid || out_ready;
    assign xfer_a      = a_valid && a_ready;
    assign xfer_b      = b_valid && b_ready;
    assign own_xfer    = xfer_a || xfer_b;
    // In a grant state sel always names the owner, so it doubles as the owner index.
    assign own_valid   = (sel == SEL_B) ? b_valid : a_valid;
    assign other_valid = (sel == SEL_B) ? a_valid : b_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= SEL_A;
            last  <= SEL_B;
`ifdef ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
`ifdef ARB_LOCK_EN
            lock_cnt <= lock_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        sel_nxt   = sel;
        case (state)
            ST_IDLE: begin
                if (a_valid && (!b_valid || last == SEL_B))
                    state_nxt = ST_GNT_A;
                else if (b_valid)
                    state_nxt = ST_GNT_B;
            end
            ST_GNT_A, ST_GNT_B: begin
                if (own_xfer) begin
                    last_nxt = sel;
                    if (other_valid && !hold_lock)
                        state_nxt = grant_of(!sel);
                end else if (!own_valid) begin
                    // owner went quiet after its last beat; release rather than block the other side
                    state_nxt = other_valid ? grant_of(!sel) : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_GNT_A)
            sel_nxt = SEL_A;
        else if (state_nxt == ST_GNT_B)
            sel_nxt = SEL_B;
`ifdef ARB_LOCK_EN
        lock_cnt_nxt = lock_cnt;
        if (state_nxt != state || (own_xfer && !hold_lock))
            lock_cnt_nxt = '0;
        else if (own_xfer && !lock_at_max)
            lock_cnt_nxt = lock_cnt + 1'b1;
`endif
    end

    always_comb begin
        a_ready = (state == ST_GNT_A) && free;
        b_ready = (state == ST_GNT_B) && free;
    end

    MUX_32Bits #(.WIDTH(WIDTH)) u_mux (
        .d0     (a_data),
        .d1     (b_data),
        .select (sel),
        .y      (mux_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (own_xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
